// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_intf responder, its transaction class and tests.
// Command decode: a read and a write in the same cycle is a collision, not a read-modify-write.
package mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        CMD_IDLE,
        CMD_RD,
        CMD_WR,
        CMD_COLL
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic rd, input logic wr);
        cmd_e c;
        c = CMD_IDLE;
        if (rd && wr) begin
            c = CMD_COLL;
        end else if (rd) begin
            c = CMD_RD;
        end else if (wr) begin
            c = CMD_WR;
        end
        return c;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-data delay line: RD_LAT stages of {valid, data}, stage 0 loaded at the command edge.
// Latency RD_LAT clocks; no backpressure, one entry may enter every cycle.
module mem_rd_pipe #(
    parameter int RD_LAT = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat
);

    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    // Only the valid bits need reset; stale data behind a cleared valid is never consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dat_q[0] <= in_dat;
        for (int i = 1; i < RD_LAT; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign out_vld = vld_q[RD_LAT-1];
    assign out_dat = dat_q[RD_LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: DEPTH x DATA_W store, collision flag and saturating access counters.
// Read data returns RD_LAT clocks after the command edge with a one-cycle rd_valid; no backpressure.
module mem_responder
    import mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_responder: RD_LAT must be in 1..4");
    end
    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("mem_responder: DEPTH must equal 2**ADDR_W");
    end

    cmd_e             cmd;
    data_t            mem_q [DEPTH];
    logic             err_q, err_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    data_t            dout_q;
    logic             rvld_q;
    logic             pipe_vld;
    data_t            pipe_dat;

    assign cmd = decode_cmd(read, write);

    // Clear is applied first so a command in the same cycle lands on the cleared values.
    always_comb begin
        err_d    = err_clr ? 1'b0 : err_q;
        wr_cnt_d = err_clr ? '0 : wr_cnt_q;
        rd_cnt_d = err_clr ? '0 : rd_cnt_q;
        case (cmd)
            CMD_WR: begin
                if (wr_cnt_d != '1) begin
                    wr_cnt_d = wr_cnt_d + 16'd1;
                end
            end
            CMD_RD: begin
                if (rd_cnt_d != '1) begin
                    rd_cnt_d = rd_cnt_d + 16'd1;
                end
            end
            CMD_COLL: err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            err_q    <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            dout_q   <= '0;
            rvld_q   <= 1'b0;
        end else begin
            if (cmd == CMD_WR) begin
                mem_q[addr] <= data_in;
            end
            err_q    <= err_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            rvld_q   <= pipe_vld;
            if (pipe_vld) begin
                dout_q <= pipe_dat;
            end
        end
    end

    mem_rd_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (cmd == CMD_RD),
        .in_dat  (mem_q[addr]),
        .out_vld (pipe_vld),
        .out_dat (pipe_dat)
    );

    assign data_out = dout_q;
    assign rd_valid = rvld_q;
    assign err      = err_q;
    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Three responders (RD_LAT 1, 3, 4) share one stimulus stream; a queue-based model predicts reads.
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        read, write, err_clr;
    logic [4:0]  addr;
    logic [7:0]  data_in;

    logic [2:0][7:0]  dout;
    logic [2:0]       rv;
    logic [2:0]       er;
    logic [2:0][15:0] wc;
    logic [2:0][15:0] rc;

    mem_responder #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
        .data_in(data_in), .data_out(dout[0]), .rd_valid(rv[0]), .err(er[0]),
        .err_clr(err_clr), .wr_count(wc[0]), .rd_count(rc[0]));

    mem_responder #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
        .data_in(data_in), .data_out(dout[1]), .rd_valid(rv[1]), .err(er[1]),
        .err_clr(err_clr), .wr_count(wc[1]), .rd_count(rc[1]));

    mem_responder #(.RD_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
        .data_in(data_in), .data_out(dout[2]), .rd_valid(rv[2]), .err(er[2]),
        .err_clr(err_clr), .wr_count(wc[2]), .rd_count(rc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Reference model: memory contents, counters, sticky flag, and the ordered list of reads.
    typedef struct {
        logic [7:0] d;
        int         e;
    } exp_t;

    logic [7:0] ref_mem [32];
    int         m_wr, m_rd;
    logic       m_err;
    exp_t       exp_q [$];

    int         idx [3];
    logic [7:0] exp_dout [3];
    int         n_cmp = 0;
    int         n_fail = 0;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    task automatic check(input string name, input int g, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s dut_lat%0d at edge %0d: got %0h, want %0h",
                     name, lat_of(g), edge_n, act, req);
        end
    endtask

    // Monitor: every falling edge, compare each DUT against the model.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst_n) begin
                idx[g]      = exp_q.size();
                exp_dout[g] = 8'h00;
                check("rst_rd_valid", g, int'(rv[g]), 0);
                check("rst_data_out", g, int'(dout[g]), 0);
            end else begin
                while (idx[g] < exp_q.size() && exp_q[idx[g]].e + lat_of(g) < edge_n) begin
                    check("rd_valid_missing", g, 0, 1);
                    idx[g]++;
                end
                if (rv[g]) begin
                    if (idx[g] < exp_q.size() && exp_q[idx[g]].e + lat_of(g) == edge_n) begin
                        check("rd_data", g, int'(dout[g]), int'(exp_q[idx[g]].d));
                        exp_dout[g] = exp_q[idx[g]].d;
                        idx[g]++;
                    end else begin
                        check("rd_valid_spurious", g, 1, 0);
                    end
                end else begin
                    check("data_out_hold", g, int'(dout[g]), int'(exp_dout[g]));
                end
            end
            check("err", g, int'(er[g]), int'(m_err));
            check("wr_count", g, int'(wc[g]), m_wr);
            check("rd_count", g, int'(rc[g]), m_rd);
        end
    end

    // One command cycle: drive just after a rising edge, update the model at the next edge.
    task automatic cyc(input logic r, input logic w, input logic [4:0] a,
                       input logic [7:0] d, input logic c);
        int issue;
        read = r; write = w; addr = a; data_in = d; err_clr = c;
        issue = edge_n + 1;
        @(posedge clk);
        if (c) begin
            m_err = 1'b0; m_wr = 0; m_rd = 0;
        end
        if (r && w) begin
            m_err = 1'b1;
        end else if (w) begin
            ref_mem[a] = d;
            if (m_wr < 65535) m_wr++;
        end else if (r) begin
            exp_q.push_back('{d: ref_mem[a], e: issue});
            if (m_rd < 65535) m_rd++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        read = 1'b0; write = 1'b0; err_clr = 1'b0; addr = '0; data_in = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        m_wr = 0; m_rd = 0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        read = 1'b0; write = 1'b0; err_clr = 1'b0; addr = '0; data_in = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        m_wr = 0; m_rd = 0; m_err = 1'b0;
        for (int g = 0; g < 3; g++) begin
            idx[g] = 0; exp_dout[g] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reads of a freshly reset store.
        for (int a = 0; a < 32; a++) cyc(1'b1, 1'b0, 5'(a), 8'h00, 1'b0);
        idle(6);

        // Write addr pattern, then read it back.
        cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
        for (int a = 0; a < 32; a++) cyc(1'b0, 1'b1, 5'(a), 8'(a), 1'b0);
        for (int a = 0; a < 32; a++) cyc(1'b1, 1'b0, 5'(a), 8'h00, 1'b0);
        idle(6);

        // Read-after-write and write-after-read ordering.
        cyc(1'b0, 1'b1, 5'd5, 8'hA5, 1'b0);
        cyc(1'b1, 1'b0, 5'd5, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 5'd5, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 5'd5, 8'h3C, 1'b0);
        cyc(1'b1, 1'b0, 5'd5, 8'h00, 1'b0);
        idle(6);

        // Collision leaves memory and counters untouched, then clear.
        cyc(1'b1, 1'b1, 5'd7, 8'hFF, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 5'd7, 8'h00, 1'b0);
        idle(5);
        cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
        cyc(1'b1, 1'b1, 5'd3, 8'h11, 1'b1);
        cyc(1'b1, 1'b0, 5'd3, 8'h00, 1'b1);
        idle(6);

        // Randomized mix including back-to-back reads, collisions and clears.
        for (int i = 0; i < 600; i++) begin
            int op;
            logic c;
            op = $urandom_range(0, 9);
            c  = ($urandom_range(0, 15) == 0);
            case (op)
                0, 1, 2, 3: cyc(1'b1, 1'b0, 5'($urandom), 8'($urandom), c);
                4, 5, 6:    cyc(1'b0, 1'b1, 5'($urandom), 8'($urandom), c);
                7:          cyc(1'b1, 1'b1, 5'($urandom), 8'($urandom), c);
                default:    cyc(1'b0, 1'b0, 5'($urandom), 8'($urandom), c);
            endcase
        end
        idle(6);

        // Write counter saturation.
        cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
        for (int i = 0; i < 70000; i++) cyc(1'b0, 1'b1, 5'($urandom), 8'($urandom), 1'b0);
        idle(2);

        // Reset while a long-latency read is in flight.
        cyc(1'b0, 1'b1, 5'd2, 8'h77, 1'b0);
        cyc(1'b1, 1'b0, 5'd2, 8'h00, 1'b0);
        idle(1);
        do_reset();
        idle(8);
        cyc(1'b1, 1'b0, 5'd2, 8'h00, 1'b0);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the mem_intf read/write protocol.
- The test initiator drives `read`, `write`, `addr` and `data_in`.
- This block owns a DEPTH x DATA_W register-file store and returns read data through a configurable-latency pipeline with a valid strobe.
- It flags illegal read+write collisions and keeps saturating access counters for the bench to check coverage.

Parameters:
- ADDR_W, 5, address width.
- DATA_W, 8, data width.
- DEPTH, 32, number of words (must equal 2**ADDR_W).
- RD_LAT, 1, read latency in clocks from command cycle to rd_valid. Legal range 1..4; elaboration error otherwise.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- read  in  1  read command, sampled at posedge.
- write  in  1  write command, sampled at posedge.
- addr  in  ADDR_W  word address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data; holds the last returned value.
- rd_valid  out  1  one-cycle pulse when data_out is updated by a read.
- err  out  1  sticky collision flag.
- err_clr  in  1  synchronous clear for err and both counters.
- wr_count  out  16  accepted writes, saturating.
- rd_count  out  16  accepted reads, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All DEPTH words cleared to 0.
  - Pipeline valid bits cleared.
  - data_out=0, rd_valid=0, err=0, wr_count=0, rd_count=0.
  - Reset mid-read flushes in-flight reads; no rd_valid follows reset release.
- Command decode per posedge, after err_clr handling: IDLE (r=0,w=0), RD (r=1,w=0), WR (r=0,w=1), COLL (r=1,w=1).
- WR:
  - mem[addr] <= data_in at this edge.
  - wr_count increments unless it is already 16'hFFFF.
- RD:
  - mem[addr] is captured into pipeline stage 0 at this edge, together with valid=1. The value is the array content before this edge.
  - data_out <= captured value and rd_valid=1 exactly RD_LAT cycles after the command edge.
  - rd_count increments with saturation.
- COLL:
  - No memory access and no counter change.
  - err <= 1 and stays set until err_clr or reset.
  - No rd_valid results.
- IDLE: no state change except the pipeline advancing.
- Throughput: back-to-back RD every cycle is supported; each produces its own rd_valid RD_LAT later, in order.
- Ordering:
  - WR to address A at edge N, RD of A at edge N+1: returns the new data.
  - RD of A at edge N, WR to A at edge N+1: the read still returns the old data, because data is captured at issue.
- err_clr:
  - Clears err and both counters at the edge.
  - If a command is present in the same cycle, it is then applied on top: COLL sets err again; RD/WR set the corresponding count to 1.
- data_out changes only on rd_valid cycles or reset.
- rd_valid is never high on consecutive cycles unless reads were issued on consecutive cycles.
- Address is always in range, because DEPTH = 2**ADDR_W.
- No X on outputs after reset.

Decomposition:
- Package mem_pkg:
  - Constants: ADDR_W, DATA_W, DEPTH.
  - Typedefs: addr_t, data_t.
  - Enum cmd_e {CMD_IDLE, CMD_RD, CMD_WR, CMD_COLL} and a function decoding {read, write} to cmd_e.
  - The same package is shared with the transaction class and the test.
- Sub-module mem_rd_pipe: RD_LAT-deep shift register of {valid, data_t}, with async reset of valid bits. mem_responder instantiates one.

Test Plan:
- Reset, then RD of addrs 0..31 with RD_LAT=1 -> every rd_valid returns 8'h00; rd_count=32, wr_count=0, err=0.
- Write data=addr to 0..31, then read back with RD_LAT=3 -> rd_valid exactly 3 cycles after each RD; data_out=addr; wr_count=32, rd_count=32.
- WR addr 5 = 8'hA5, then RD addr 5 next cycle -> 8'hA5. Then RD addr 5 followed by WR addr 5 = 8'h3C next cycle -> the read returns 8'hA5.
- read=1 and write=1 at addr 7 with data_in=8'hFF -> err=1, mem[7] unchanged (RD shows the prior value), counters unchanged, no rd_valid. Then err_clr for one cycle -> err=0, counters=0.
- 70000 writes without clear -> wr_count sticks at 16'hFFFF, no wrap.
- RD_LAT=4: issue RD at addr 2, assert rst_n=0 two cycles later, release -> no rd_valid ever appears, data_out=0, mem[2]=0.
